// File: rtl/sigmoid_arbiter_pkg.sv
// Shared types and constants for the sigmoid arbiter slice.
package sigmoid_arbiter_pkg;

    localparam int FLOAT_W     = 32;
    localparam int SIG_LAT_DEF = 1;

    typedef struct packed {
        logic       sgn;
        logic [7:0] exp;
        logic [22:0] man;
    } float_24_8;

endpackage

// File: rtl/sigmoid_arbiter_rr.sv
// Combinational round-robin arbiter: first eligible requester at or after ptr wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        // Walk the ring backwards so the candidate closest to ptr is assigned last.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr) + k) % NUM_REQ;
            if (eligible[idx]) begin
                grant_idx = IDX_W'(idx);
                grant_any = 1'b1;
            end
        end
        grant = NUM_REQ'(grant_any) << grant_idx;
    end

endmodule

// File: rtl/sigmoid_arbiter.sv
// Shares one sigmoid unit between NUM_REQ requesters with per-requester result slots.
// Optional per-requester grant counters are enabled with SIGMOID_ARB_STATS_EN.
module sigmoid_arbiter
    import sigmoid_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int SIG_LAT = SIG_LAT_DEF,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*FLOAT_W-1:0] req_data,
    output logic [FLOAT_W-1:0]         sig_in,
    input  logic [FLOAT_W-1:0]         sig_out,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [NUM_REQ*FLOAT_W-1:0] rsp_data,
    output logic                       busy
`ifdef SIGMOID_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]      grant_cnt
`endif
);

    logic [NUM_REQ-1:0]              pending;
    logic [IDX_W-1:0]                ptr;
    logic [SIG_LAT-1:0]              vld_pipe;
    logic [SIG_LAT-1:0][IDX_W-1:0]   tag_pipe;
    logic [NUM_REQ-1:0][FLOAT_W-1:0] rsp_q;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic               exit_vld;
    logic [IDX_W-1:0]   exit_tag;
    float_24_8          sel_op;

    assign eligible = req_valid & ~pending & ~rsp_valid;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .eligible  (eligible),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign req_ready = grant;
    assign sel_op    = grant_any ? float_24_8'(req_data[grant_idx*FLOAT_W +: FLOAT_W]) : '0;
    assign sig_in    = sel_op;

    assign exit_vld  = vld_pipe[SIG_LAT-1];
    assign exit_tag  = tag_pipe[SIG_LAT-1];
    assign rsp_data  = rsp_q;
    assign busy      = (|pending) | (|rsp_valid) | (|vld_pipe);

    always_ff @(posedge clk) begin
        if (reset) begin
            pending   <= '0;
            ptr       <= '0;
            vld_pipe  <= '0;
            tag_pipe  <= '0;
            rsp_valid <= '0;
            rsp_q     <= '0;
        end else begin
            vld_pipe[0] <= grant_any;
            tag_pipe[0] <= grant_idx;
            for (int s = 1; s < SIG_LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                tag_pipe[s] <= tag_pipe[s-1];
            end
            if (grant_any)
                ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            // Capture and accept never hit the same slot: a slot is reserved until accepted.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i])
                    pending[i] <= 1'b1;
                else if (exit_vld && exit_tag == IDX_W'(i))
                    pending[i] <= 1'b0;
                if (exit_vld && exit_tag == IDX_W'(i)) begin
                    rsp_valid[i] <= 1'b1;
                    rsp_q[i]     <= sig_out;
                end else if (rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

`ifdef SIGMOID_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (grant[i] && cnt[i] != 16'hFFFF)
                    cnt[i] <= cnt[i] + 16'd1;
        end
    end

    assign grant_cnt = cnt;
`endif

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Randomized bench for sigmoid_arbiter against a transaction-level reference model.
module tb_sigmoid_arbiter;

    localparam int N   = 4;
    localparam int LAT = 1;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*32-1:0] req_data, rsp_data;
    logic [31:0]     sig_in, sig_out;
    logic            busy;
`ifdef SIGMOID_ARB_STATS_EN
    logic [N*16-1:0] grant_cnt;
`endif

    always #5 clk = ~clk;

    sigmoid_arbiter #(.NUM_REQ(N), .SIG_LAT(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .sig_in    (sig_in),
        .sig_out   (sig_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
`ifdef SIGMOID_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    // Stand-in sigmoid: saturates for |x| >= 32, otherwise a fixed scramble so each operand is traceable.
    function automatic logic [31:0] sig_fn(input logic [31:0] x);
        if (x[30:23] >= 8'h84) return x[31] ? 32'h0000_0000 : 32'h3F80_0000;
        return x ^ 32'h3C5A_1E0F;
    endfunction

    logic [31:0] sp [LAT];
    always_ff @(posedge clk) begin
        sp[0] <= sig_fn(sig_in);
        for (int k = 1; k < LAT; k++) sp[k] <= sp[k-1];
    end
    assign sig_out = sp[LAT-1];

    typedef struct {
        int          idx;
        logic [31:0] d;
        int          cap;
    } flight_t;

    bit          m_pend [N];
    bit          m_hold [N];
    logic [31:0] m_data [N];
    int          m_cnt  [N];
    int          m_ptr;
    int          cyc;
    flight_t     fly [$];

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_hold[i] = 0; m_data[i] = '0; m_cnt[i] = 0;
        end
        m_ptr = 0;
        fly.delete();
    endtask

    // One clock: drive inputs, check against the model, take the edge, advance the model.
    task automatic step(input logic rst, input logic [N-1:0] v, input logic [N*32-1:0] d,
                        input logic [N-1:0] rr);
        int g;
        bit any;
        flight_t keep [$];
        reset = rst; req_valid = v; req_data = d; rsp_ready = rr;
        #3;
        g = 0; any = 0;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (!any && v[i] && !m_pend[i] && !m_hold[i]) begin g = i; any = 1; end
        end
        chk("req_ready", 64'(req_ready), any ? 64'(1 << g) : 64'd0);
        chk("sig_in", 64'(sig_in), any ? 64'(d[g*32 +: 32]) : 64'd0);
        chk("busy", 64'(busy), 64'(m_pend.or() | m_hold.or()));
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rsp_valid%0d", i), 64'(rsp_valid[i]), 64'(m_hold[i]));
            chk($sformatf("rsp_data%0d", i), 64'(rsp_data[i*32 +: 32]), 64'(m_data[i]));
`ifdef SIGMOID_ARB_STATS_EN
            chk($sformatf("grant_cnt%0d", i), 64'(grant_cnt[i*16 +: 16]), 64'(m_cnt[i]));
`endif
        end
        @(posedge clk); #1;
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < N; i++) if (m_hold[i] && rr[i]) m_hold[i] = 0;
            foreach (fly[j]) begin
                if (fly[j].cap == cyc) begin
                    m_hold[fly[j].idx] = 1;
                    m_pend[fly[j].idx] = 0;
                    m_data[fly[j].idx] = sig_fn(fly[j].d);
                end else begin
                    keep.push_back(fly[j]);
                end
            end
            fly = keep;
            if (any) begin
                m_pend[g] = 1;
                fly.push_back('{g, d[g*32 +: 32], cyc + LAT});
                m_ptr = (g + 1) % N;
                if (m_cnt[g] < 65535) m_cnt[g]++;
            end
        end
        cyc++;
    endtask

    function automatic logic [N*32-1:0] rnd_data();
        logic [N*32-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[i*32 +: 32] = $urandom;
            if ($urandom_range(3) == 0) r[i*32 +: 32] = {r[i*32+31], 8'h85, r[i*32 +: 23]};
        end
        return r;
    endfunction

    initial begin
        logic [N*32-1:0] d;
        cyc = 0;
        model_reset();
        reset = 1'b1; req_valid = '0; req_data = '0; rsp_ready = '0;
        #1;
        step(1, '0, '0, '0);
        step(1, '0, '0, '0);

        // Single requester: +32.0 saturates to 1.0 two cycles after grant.
        d = '0; d[31:0] = 32'h4200_0000;
        step(0, 4'b0001, d, 4'b1111);
        for (int c = 0; c < 4; c++) step(0, '0, d, 4'b1111);

        // Negative saturation on requester 2.
        d = '0; d[95:64] = 32'hC200_0000;
        step(0, 4'b0100, d, 4'b1111);
        for (int c = 0; c < 4; c++) step(0, '0, d, 4'b1111);

        // Round-robin: everyone valid, everyone accepting.
        for (int c = 0; c < 20; c++) step(0, 4'b1111, rnd_data(), 4'b1111);

        // Backpressure on requester 1.
        d = rnd_data();
        for (int c = 0; c < 12; c++) step(0, 4'b1111, d, 4'b1101);
        for (int c = 0; c < 6; c++) step(0, 4'b1111, d, 4'b1111);

        // Reset with operands in flight.
        step(1, '0, '0, '0);
        d = rnd_data();
        step(0, 4'b1001, d, 4'b0000);
        step(0, 4'b1001, d, 4'b0000);
        step(1, '0, d, 4'b0000);
        for (int c = 0; c < 4; c++) step(0, 4'b1111, rnd_data(), 4'b1111);

        // Five operands from requester 3 after a clean reset.
        step(1, '0, '0, '0);
        for (int c = 0; c < 40 && m_cnt[3] < 5; c++) step(0, 4'b1000, rnd_data(), 4'b1111);
        for (int c = 0; c < 4; c++) step(0, '0, '0, 4'b1111);

        // Random traffic with occasional resets.
        for (int c = 0; c < 2000; c++) begin
            logic r;
            logic [N-1:0] v, a;
            r = ($urandom_range(199) == 0);
            v = r ? '0 : N'($urandom);
            a = N'($urandom) | N'($urandom);
            step(r, v, rnd_data(), a);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
